// File: rtl/t06_tone_pkg.sv
// Shared constants for the team_06 tone player: state codes, half-period table
// and the state-to-half-period lookup.
package t06_tone_pkg;

  localparam logic [5:0] ST_IDLE = 6'd0;
  localparam logic [5:0] ST_GOOD = 6'd34;
  localparam logic [5:0] ST_BAD  = 6'd35;

  localparam logic [15:0] CHIRP_HALF = 16'd5682;
  localparam logic [15:0] BUZZ_HALF  = 16'd45455;

  localparam logic [3:0] LEVEL_MAX   = 4'd15;
  localparam logic [3:0] LEVEL_FLOOR = 4'd4;

  // Diatonic G6..A8 at 10 MHz: half = 10e6 / (2 * f)
  localparam logic [15:0] NOTE_HALF [16] = '{
    16'd3189, 16'd2841, 16'd2531, 16'd2389,
    16'd2128, 16'd1896, 16'd1790, 16'd1594,
    16'd1420, 16'd1265, 16'd1194, 16'd1064,
    16'd948,  16'd895,  16'd797,  16'd710
  };

  function automatic logic [15:0] half_for_state(input logic [5:0] st);
    if (st == ST_GOOD) return CHIRP_HALF;
    if (st == ST_BAD)  return BUZZ_HALF;
    if (st[0] && (st <= 6'd31)) return NOTE_HALF[st[4:1]];
    return 16'd0;
  endfunction

endpackage

// File: rtl/t06_tone_envelope.sv
// Decaying volume envelope with 4-bit PWM gate; exists only when
// TONE_ENVELOPE_EN is defined.
`ifdef TONE_ENVELOPE_EN
module t06_tone_envelope
  import t06_tone_pkg::*;
#(
  parameter int DECAY_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  input  logic active_i,
  input  logic square_i,
  output logic sound_o
);

  localparam int DW = $clog2(DECAY_CYCLES + 1);

  logic [DW-1:0] r_decay;
  logic [3:0]    r_level;
  logic [3:0]    r_pwm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_decay <= '0;
      r_level <= LEVEL_MAX;
      r_pwm   <= 4'd0;
    end else begin
      r_pwm <= r_pwm + 4'd1;
      if (restart_i) begin
        r_decay <= '0;
        r_level <= LEVEL_MAX;
      end else if (active_i) begin
        if (r_decay == DW'(DECAY_CYCLES - 1)) begin
          r_decay <= '0;
          if (r_level > LEVEL_FLOOR) r_level <= r_level - 4'd1;
        end else begin
          r_decay <= r_decay + DW'(1);
        end
      end
    end
  end

  assign sound_o = square_i & (r_pwm < r_level);

endmodule
`endif

// File: rtl/t06_tone_player.sv
// Square-wave tone player for the team_06 sound sequencer.
// Optional decaying envelope enabled with TONE_ENVELOPE_EN.
module t06_tone_player
  import t06_tone_pkg::*;
#(
  parameter int HALF_W = 16
`ifdef TONE_ENVELOPE_EN
  ,
  parameter int DECAY_CYCLES = 250000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] state_i,
  input  logic       enable_i,
  output logic       sound_o,
  output logic       note_start_o,
  output logic       active_o
);

  logic [5:0]        r_state_q;
  logic [HALF_W-1:0] r_cnt;
  logic              r_square;
  logic              r_note_start;
  logic              r_active;

  logic              w_change;
  logic              w_run;
  logic [HALF_W-1:0] w_half;
  logic [HALF_W-1:0] w_half_in;

  assign w_change  = (state_i != r_state_q);
  assign w_half    = HALF_W'(half_for_state(r_state_q));
  assign w_half_in = HALF_W'(half_for_state(state_i));
  // Gating on r_active gives an enable rise the same restart timing as a state change.
  assign w_run     = (w_half != '0) && enable_i && r_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q    <= ST_IDLE;
      r_cnt        <= '0;
      r_square     <= 1'b0;
      r_note_start <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_state_q    <= state_i;
      r_note_start <= w_change && (w_half_in != '0) && enable_i;
      r_active     <= (w_half_in != '0) && enable_i;
      if (w_change || !w_run) begin
        r_cnt    <= '0;
        r_square <= 1'b0;
      end else if (r_cnt == w_half - HALF_W'(1)) begin
        r_cnt    <= '0;
        r_square <= ~r_square;
      end else begin
        r_cnt <= r_cnt + HALF_W'(1);
      end
    end
  end

  assign note_start_o = r_note_start;
  assign active_o     = r_active;

`ifdef TONE_ENVELOPE_EN
  t06_tone_envelope #(
    .DECAY_CYCLES(DECAY_CYCLES)
  ) u_env (
    .clk      (clk),
    .rst      (rst),
    .restart_i(w_change),
    .active_i (r_active),
    .square_i (r_square),
    .sound_o  (sound_o)
  );
`else
  assign sound_o = r_square;
`endif

endmodule

// File: tb/tb_t06_tone_player.sv
// Directed bench for t06_tone_player; envelope checks compile only with TONE_ENVELOPE_EN.
module tb_t06_tone_player;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] state_i;
  logic       enable_i;
  logic       sound_o;
  logic       note_start_o;
  logic       active_o;
  logic       sq;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  t06_tone_player #(
    .HALF_W(16)
`ifdef TONE_ENVELOPE_EN
    , .DECAY_CYCLES(16)
`endif
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .state_i     (state_i),
    .enable_i    (enable_i),
    .sound_o     (sound_o),
    .note_start_o(note_start_o),
    .active_o    (active_o)
  );

`ifdef TONE_ENVELOPE_EN
  assign sq = u_dut.r_square;
`else
  assign sq = sound_o;
`endif

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_sq(input logic val, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sq === val) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int t0;
    int t;
    int highs;

    // 1: reset with buzz state pending, then release
    rst = 1'b1; state_i = 6'd35; enable_i = 1'b1;
    repeat (5) @(negedge clk);
    chk_eq("rst_sound", sound_o, 0);
    chk_eq("rst_active", active_o, 0);
    chk_eq("rst_nstart", note_start_o, 0);
    rst = 1'b0;
    @(negedge clk);
    t0 = cyc;
    chk_eq("t1_nstart", note_start_o, 1);
    chk_eq("t1_active", active_o, 1);
    chk_eq("t1_sound0", sound_o, 0);
    @(negedge clk);
    chk_eq("t1_nstart_end", note_start_o, 0);
    wait_sq(1'b1, 50000);
    chk_eq("t1_first_rise", cyc - t0, 45455);

    // 5: chirp, mute 100 cycles, re-enable
    state_i = 6'd34;
    @(negedge clk);
    chk_eq("t5_nstart", note_start_o, 1);
    repeat (50) @(negedge clk);
    enable_i = 1'b0;
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sound_o) highs++;
    end
    chk_eq("t5_mute_highs", highs, 0);
    chk_eq("t5_mute_active", active_o, 0);
    enable_i = 1'b1;
    @(negedge clk);
    t0 = cyc;
    chk_eq("t5_no_nstart", note_start_o, 0);
    wait_sq(1'b1, 8000);
    chk_eq("t5_reenable_rise", cyc - t0, 5682);

    // 2: three full chirp periods
    for (int p = 0; p < 3; p++) begin
      t = cyc;
      wait_sq(1'b0, 8000);
      chk_eq("t2_high_half", cyc - t, 5682);
      wait_sq(1'b1, 8000);
      chk_eq("t2_period", cyc - t, 11364);
    end

    // 3: note 1 -> rest 2 in the middle of the high phase
    state_i = 6'd1;
    @(negedge clk);
    t0 = cyc;
    chk_eq("t3_nstart", note_start_o, 1);
    wait_sq(1'b1, 5000);
    chk_eq("t3_first_rise", cyc - t0, 3189);
    repeat (10) @(negedge clk);
    chk_eq("t3_still_high", sq, 1);
    state_i = 6'd2;
    @(negedge clk);
    chk_eq("t3_rest_sound", sound_o, 0);
    chk_eq("t3_rest_active", active_o, 0);
    chk_eq("t3_rest_nstart", note_start_o, 0);
    @(negedge clk);
    chk_eq("t3_rest_nstart2", note_start_o, 0);

    // 4: note 3 -> note 5 exactly when the counter sits at half-1
    state_i = 6'd3;
    @(negedge clk);
    t0 = cyc;
    chk_eq("t4_nstart", note_start_o, 1);
    while (cyc < t0 + 2840) @(negedge clk);
    chk_eq("t4_cnt_at_wrap", u_dut.r_cnt, 2840);
    chk_eq("t4_pre_sound", sound_o, 0);
    state_i = 6'd5;
    @(negedge clk);
    chk_eq("t4_no_toggle", sound_o, 0);
    chk_eq("t4_cnt_restart", u_dut.r_cnt, 0);
    chk_eq("t4_nstart", note_start_o, 1);
    @(negedge clk);
    chk_eq("t4_nstart_end", note_start_o, 0);
    chk_eq("t4_cnt_next", u_dut.r_cnt, 1);
    chk_eq("t4_active", active_o, 1);

`ifdef TONE_ENVELOPE_EN
    // 6: envelope decay to floor, duty at floor, reload on change
    state_i = 6'd34;
    @(negedge clk);
    t0 = cyc;
    while (cyc < t0 + 175) @(negedge clk);
    chk_eq("t6_level_175", u_dut.u_env.r_level, 5);
    @(negedge clk);
    chk_eq("t6_level_176", u_dut.u_env.r_level, 4);
    wait_sq(1'b1, 8000);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (sound_o) highs++;
    end
    chk_eq("t6_duty_floor", highs, 4);
    chk_eq("t6_level_floor", u_dut.u_env.r_level, 4);
    state_i = 6'd35;
    @(negedge clk);
    chk_eq("t6_level_reload", u_dut.u_env.r_level, 15);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
